// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode map, sequencer states and ALU select constants for cu_multicycle
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRZ  = 4'hB;
    localparam logic [3:0] OP_BRN  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    localparam logic [3:0] FS_ADDI = 4'h1;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/cu_pc_unit.sv
// rtl/cu_pc_unit.sv - program counter with increment, signed relative branch and absolute load
module cu_pc_unit #(
    parameter int PC_W   = 6,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              branch,
    input  logic              load,
    input  logic [REG_AW-1:0] offset,
    input  logic [PC_W-1:0]   target,
    output logic [PC_W-1:0]   pc
);

    logic signed [REG_AW-1:0] off_s;
    logic [PC_W-1:0]          pc_plus1;

    assign off_s    = offset;
    assign pc_plus1 = pc + PC_W'(1);

    // Sizing a signed value sign-extends the offset; all sums wrap modulo 2^PC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (branch) begin
            pc <= pc_plus1 + PC_W'(off_s);
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/cu_multicycle.sv
// rtl/cu_multicycle.sv - FETCH/EXEC/HALT control unit; CU_ILLEGAL_TRAP_EN makes opcode 0xF trap and halt
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int REG_AW  = 4,
    parameter int OP_W    = 4,
    parameter int INSTR_W = OP_W + 3 * REG_AW
) (
    input  logic               clk_main,
    input  logic               reset,
    input  logic [INSTR_W-1:0] InstructIn,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               Z,
    input  logic               N,
    input  logic [PC_W-1:0]    BusA,
    output logic               instr_req,
    output logic [PC_W-1:0]    PC,
    output logic [REG_AW-1:0]  DR,
    output logic [REG_AW-1:0]  SA,
    output logic [REG_AW-1:0]  SB,
    output logic [REG_AW-1:0]  FS,
    output logic               MB,
    output logic               MM,
    output logic               MD,
    output logic               MW,
    output logic               RW,
    output logic               halted,
    output logic               trap
);

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [OP_W-1:0]    op;
    logic               pc_inc, pc_branch, pc_load;

    assign op = ir[INSTR_W-1 -: OP_W];
    assign DR = ir[3*REG_AW-1 -: REG_AW];
    assign SA = ir[2*REG_AW-1 -: REG_AW];
    assign SB = ir[REG_AW-1:0];
    assign halted = (state == HALT);

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (state == FETCH && instr_valid) begin
            ir <= InstructIn;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic trap_set;

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            trap <= 1'b0;
        end else if (trap_set) begin
            trap <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        FS        = '0;
        MB        = 1'b0;
        MM        = 1'b0;
        MD        = 1'b0;
        MW        = 1'b0;
        RW        = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        pc_load   = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        trap_set  = 1'b0;
`endif
        case (state)
            FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                pc_inc    = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_ADDI: begin
                        MB = 1'b1;
                        FS = REG_AW'(FS_ADDI);
                        RW = 1'b1;
                    end
                    // Memory ops park in EXEC until the data memory acknowledges.
                    OP_LD: begin
                        MM = 1'b1;
                        MD = 1'b1;
                        RW = mem_ready;
                        if (!mem_ready) begin
                            state_nxt = EXEC;
                            pc_inc    = 1'b0;
                        end
                    end
                    OP_ST: begin
                        MM = 1'b1;
                        MW = 1'b1;
                        if (!mem_ready) begin
                            state_nxt = EXEC;
                            pc_inc    = 1'b0;
                        end
                    end
                    OP_BRZ: pc_branch = Z;
                    OP_BRN: pc_branch = N;
                    OP_JMP: pc_load = 1'b1;
                    OP_HALT: begin
                        state_nxt = HALT;
                        pc_inc    = 1'b0;
                    end
                    OP_ILL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        trap_set  = 1'b1;
                        state_nxt = HALT;
                        pc_inc    = 1'b0;
`endif
                    end
                    default: begin
                        FS = REG_AW'(op);
                        RW = 1'b1;
                    end
                endcase
            end
            HALT: ;
            default: state_nxt = FETCH;
        endcase
    end

    cu_pc_unit #(
        .PC_W   (PC_W),
        .REG_AW (REG_AW)
    ) u_pc (
        .clk    (clk_main),
        .rst_n  (reset),
        .inc    (pc_inc),
        .branch (pc_branch),
        .load   (pc_load),
        .offset (DR),
        .target (BusA),
        .pc     (PC)
    );

endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Parametrised multi-cycle CPU control unit: program counter, instruction register, FETCH/EXEC/HALT sequencer and decoder in one block, driving the datapath select and enable lines. Generalises the two-state fetch/execute control path with configurable PC and register-address widths, a ready/valid handshake on instruction and data memory, conditional branches on Z and N, register-indirect jump and a HALT state. Sits between instruction memory, data memory and the register-file/ALU datapath.

## Interface
- PC_W, 6: PC width; instruction address space 2^PC_W words.
- REG_AW, 4: register address width; also FS width and branch-offset width.
- OP_W, 4: opcode width (fixed encoding needs exactly 4).
- INSTR_W, OP_W+3*REG_AW: instruction width; format {opcode, DR, SA, SB}, MSB first.
- clk_main  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstructIn  in  INSTR_W  instruction word from instruction memory.
- instr_valid  in  1  InstructIn valid this cycle.
- mem_ready  in  1  data memory completed access this cycle.
- Z, N  in  1 each  zero / negative flags of current ALU result (BusA-based).
- BusA  in  PC_W  low bits of R[SA], jump target.
- instr_req  out  1  fetch request; PC valid while high.
- PC  out  PC_W  current program counter.
- DR, SA, SB  out  REG_AW each  register fields of IR.
- FS  out  REG_AW  ALU function select.
- MB, MM, MD, MW, RW  out  1 each  constant select, address select, data select, memory write, register write.
- halted, trap  out  1 each  HALT state reached; illegal opcode trapped.

## Operation
- Opcodes: 0x0 NOP; 0x1–0x7 ALU R[DR]←R[SA] op R[SB], FS=opcode, RW=1; 0x8 ADDI, MB=1, FS=0x1, SB is zero-extended immediate; 0x9 LD R[DR]←M[R[SA]], MM=1, MD=1; 0xA ST M[R[SA]]←R[SB], MM=1, MW=1; 0xB BRZ; 0xC BRN; 0xD JMP PC←BusA; 0xE HALT; 0xF illegal.
- FETCH: instr_req=1, all enables 0. On edge with instr_valid=1: IR←InstructIn, go EXEC. Otherwise hold.
- EXEC: outputs decoded from IR. Non-memory ops: one cycle, PC update, back to FETCH.
- LD/ST: stay in EXEC with MM (and MW for ST) held until mem_ready=1; LD asserts RW=mem_ready combinationally; on the ready edge PC←PC+1, go FETCH.
- PC update: default PC+1; BRZ with Z=1 / BRN with N=1: PC←PC+1+sext(DR field); JMP: PC←BusA. All arithmetic modulo 2^PC_W (wrap from 2^PC_W−1 to 0).
- HALT: from EXEC of 0xE; halted=1, instr_req=0, all enables 0, PC frozen; exit only by reset.
- Reset (any time, including mid LD/ST wait): state FETCH, PC=0, IR=0, all enables/flags 0, instr_req=1 after release.

## Timing
- Minimum 2 cycles per instruction (FETCH+EXEC); LD/ST take 2+k, k = wait cycles before mem_ready.
- instr_valid in EXEC/HALT ignored; mem_ready outside LD/ST EXEC ignored.
- Z/N sampled on the EXEC edge of the branch.
- Enables are combinational from registered state/IR; no glitch requirement beyond single-clock synchronous use.

## Configuration
- CU_ILLEGAL_TRAP_EN defined: opcode 0xF sets trap=1 and enters HALT (halted=1).
- Undefined: 0xF executes as NOP, trap tied 0.

## Structure
- Package cu_pkg: opcode localparams, state enum (FETCH, EXEC, HALT), FS constant for ADDI.
- One sub-module cu_pc_unit: PC register with increment, relative branch and absolute load, parametrised by PC_W and REG_AW.

## Test plan
- Reset, instr_valid=1 with 0x1234 -> cycle 1 IR=0x1234, FS=1, DR=2, SA=3, SB=4, RW=1; next PC=1.
- LD 0x9120, mem_ready low 3 cycles -> MM=MD=1 held 4 EXEC cycles, RW only on ready cycle, PC increments once.
- BRZ with DR=0xE, PC=5, Z=1 -> PC=4; same with Z=0 -> PC=6.
- PC=63, NOP -> PC wraps to 0; JMP with BusA=0x2A -> PC=42.
- HALT 0xE000 -> halted=1, instr_req=0, PC frozen for 20 cycles; reset mid-ST wait -> all outputs to reset values immediately.
- 0xF000 with CU_ILLEGAL_TRAP_EN -> trap=1, halted=1; without -> PC+1, trap=0.
